// File: rtl/jp3_stream_deframer.sv
// jp3_stream_deframer: comma lock + K-framed record parser after the 8b10b decoder.
// In: CLK_80M, RESET, ByteIn/KIn/CodeErr/ByteValid, CntClr, HitReady.
// Out: HitData/HitSrc/HitValid (FWFT FIFO), StatusByte/StatusValid,
//      Locked, WordCnt, ErrCnt, DropCnt, Overflow.
module jp3_stream_deframer #(
  parameter int OUT_DEPTH   = 8,
  parameter int LOCK_COMMAS = 4,
  parameter int LOSS_ERRS   = 3
) (
  input  logic        CLK_80M,
  input  logic        RESET,
  input  logic [7:0]  ByteIn,
  input  logic        KIn,
  input  logic        CodeErr,
  input  logic        ByteValid,
  input  logic        CntClr,
  output logic [15:0] HitData,
  output logic [1:0]  HitSrc,
  output logic        HitValid,
  input  logic        HitReady,
  output logic [7:0]  StatusByte,
  output logic        StatusValid,
  output logic        Locked,
  output logic [31:0] WordCnt,
  output logic [15:0] ErrCnt,
  output logic [15:0] DropCnt,
  output logic        Overflow
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    UNLOCKED, IDLE, D_HI, D_LO, STAT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    comma_run_q, comma_run_d;
  logic [3:0]    err_run_q, err_run_d;
  logic [1:0]    src_q, src_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    status_byte_q, status_byte_d;
  logic          status_valid_q, status_valid_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   word_cnt_q, word_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;
  logic [17:0]   mem_q [OUT_DEPTH];

  logic is_comma, is_dhdr, is_shdr, is_data;
  logic err_ev, wr_req, accept, drop, pop, full, hit_valid;

  always_comb begin
    is_comma = KIn && !CodeErr && (ByteIn == 8'hBC);
    // K28.0..K28.3 are 0x1C/0x3C/0x5C/0x7C; bits [6:5] give the source index
    is_dhdr  = KIn && !CodeErr && !ByteIn[7] && (ByteIn[4:0] == 5'h1C);
    is_shdr  = KIn && !CodeErr && (ByteIn == 8'h9C);
    is_data  = !KIn && !CodeErr;
  end

  always_comb begin
    state_d        = state_q;
    comma_run_d    = comma_run_q;
    err_run_d      = err_run_q;
    src_d          = src_q;
    hi_d           = hi_q;
    status_byte_d  = status_byte_q;
    status_valid_d = 1'b0;
    err_ev         = 1'b0;
    wr_req         = 1'b0;
    if (ByteValid) begin
      unique case (state_q)
        UNLOCKED: begin
          if (!is_comma) begin
            comma_run_d = '0;
          end else if (comma_run_q == 4'(LOCK_COMMAS - 1)) begin
            state_d     = IDLE;
            comma_run_d = '0;
            err_run_d   = '0;
          end else begin
            comma_run_d = comma_run_q + 4'd1;
          end
        end
        IDLE: begin
          if (is_comma) begin
            err_run_d = '0;
          end else if (is_dhdr) begin
            src_d   = ByteIn[6:5];
            state_d = D_HI;
          end else if (is_shdr) begin
            state_d = STAT;
          end else begin
            err_ev = 1'b1;
          end
        end
        D_HI: begin
          if (is_data) begin
            hi_d    = ByteIn;
            state_d = D_LO;
          end else begin
            err_ev = 1'b1;
          end
        end
        D_LO: begin
          if (is_data) begin
            wr_req  = 1'b1;
            state_d = IDLE;
          end else begin
            err_ev = 1'b1;
          end
        end
        STAT: begin
          if (is_data) begin
            status_byte_d  = ByteIn;
            status_valid_d = 1'b1;
            state_d        = IDLE;
          end else begin
            err_ev = 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
      if (err_ev) begin
        state_d = IDLE;
        // a comma that breaks a record still resynchronises the run
        if (is_comma) begin
          err_run_d = '0;
        end else if (err_run_q == 4'(LOSS_ERRS - 1)) begin
          state_d     = UNLOCKED;
          comma_run_d = '0;
          err_run_d   = '0;
        end else begin
          err_run_d = err_run_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    hit_valid = (count_q != '0);
    full      = (count_q == CW'(OUT_DEPTH));
    pop       = hit_valid && HitReady;
    accept    = wr_req && (!full || pop);
    drop      = wr_req && full && !pop;
    wr_ptr_d  = wr_ptr_q + AW'(accept);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(accept) - CW'(pop);

    word_cnt_d = word_cnt_q + 32'(accept);
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q || drop;
    if (err_ev && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (CntClr) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_80M) begin
    if (RESET) begin
      state_q        <= UNLOCKED;
      comma_run_q    <= '0;
      err_run_q      <= '0;
      src_q          <= '0;
      hi_q           <= '0;
      status_byte_q  <= '0;
      status_valid_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      word_cnt_q     <= '0;
      err_cnt_q      <= '0;
      drop_cnt_q     <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      comma_run_q    <= comma_run_d;
      err_run_q      <= err_run_d;
      src_q          <= src_d;
      hi_q           <= hi_d;
      status_byte_q  <= status_byte_d;
      status_valid_q <= status_valid_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      word_cnt_q     <= word_cnt_d;
      err_cnt_q      <= err_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      overflow_q     <= overflow_d;
    end
  end

  always_ff @(posedge CLK_80M) begin
    if (!RESET && accept) mem_q[wr_ptr_q] <= {src_q, hi_q, ByteIn};
  end

  // storage is not reset, so the head is masked while empty
  assign HitValid    = hit_valid;
  assign HitData     = hit_valid ? mem_q[rd_ptr_q][15:0] : '0;
  assign HitSrc      = hit_valid ? mem_q[rd_ptr_q][17:16] : '0;
  assign StatusByte  = status_byte_q;
  assign StatusValid = status_valid_q;
  assign Locked      = (state_q != UNLOCKED);
  assign WordCnt     = word_cnt_q;
  assign ErrCnt      = err_cnt_q;
  assign DropCnt     = drop_cnt_q;
  assign Overflow    = overflow_q;

endmodule

// File: doc/jp3_stream_deframer.md
Name: jp3_stream_deframer

Overview:
- FPGA-side stage directly downstream of the chip's 8b10b decoder, one decoded byte per clock.
- Acquires comma lock and parses K-symbol-framed records: hit words from FIFO1..4 and status bytes.
- Buffers hit words in a small output FIFO with valid/ready handshake and keeps word and error counters for slow control.

Parameters:
OUT_DEPTH, 8, output FIFO depth in words (power of 2, 2..64)
LOCK_COMMAS, 4, consecutive commas required to acquire lock (1..15)
LOSS_ERRS, 3, errors without an intervening comma that drop lock (1..15)

Ports:
CLK_80M  in  1  byte clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
ByteIn  in  8  decoded byte (decoder output, bit 0 = A)
KIn  in  1  ByteIn is a K symbol
CodeErr  in  1  decoder code/disparity violation on this byte
ByteValid  in  1  ByteIn/KIn/CodeErr qualifier
CntClr  in  1  synchronous clear of counters and Overflow
HitData  out  16  hit word, first byte in [15:8]
HitSrc  out  2  source FIFO index (0 = FIFO1 .. 3 = FIFO4)
HitValid  out  1  HitData/HitSrc valid
HitReady  in  1  consumer accepts the word when HitValid and HitReady are both high
StatusByte  out  8  last received status byte
StatusValid  out  1  one-cycle pulse: StatusByte updated
Locked  out  1  comma lock acquired
WordCnt  out  32  hit words written to FIFO, wraps
ErrCnt  out  16  error events, saturates at 0xFFFF
DropCnt  out  16  words dropped on full FIFO, saturates
Overflow  out  1  sticky: a word was dropped

Behaviour:
- Symbols (KIn=1): 0xBC K28.5 comma; 0x1C/0x3C/0x5C/0x7C (K28.0..K28.3) = data header for FIFO1..4; 0x9C K28.4 = status header. Any other K value is an error.
- ByteValid=0: no state, counter or FIFO-write change. The FIFO read path still operates.
- Reset: all outputs 0, FIFO empty, state UNLOCKED, comma run and error run counters 0.
- UNLOCKED:
  - A valid comma increments the run counter; a valid non-comma clears it. No errors are counted.
  - Reaching LOCK_COMMAS moves to IDLE; Locked=1 from the next cycle.
- IDLE:
  - Comma: stay; clear the error run.
  - Data header: latch src, go to D_HI.
  - Status header: go to STAT.
  - Data byte (K=0), unknown K, or CodeErr: error.
- D_HI: data byte latched as high byte, go to D_LO. Any K or CodeErr: error.
- D_LO: data byte completes the word; write {src, hi, lo} to FIFO, WordCnt++, go to IDLE. Any K or CodeErr: error.
- STAT: data byte loads StatusByte and pulses StatusValid on the next cycle, go to IDLE. Any K or CodeErr: error.
- Error handling:
  - Increment ErrCnt and the error run; discard the partial record; go to IDLE.
  - A comma that raises the error also counts as a comma: e.g. a comma in D_HI gives an error, then IDLE with the error run cleared.
  - Error run reaching LOSS_ERRS: go to UNLOCKED, Locked=0 next cycle, comma run cleared.
- Output FIFO:
  - First-word-fall-through. A word written at edge N is visible with HitValid=1 after edge N, provided the FIFO was empty.
  - Pop on HitValid & HitReady.
  - Write while full with no simultaneous pop: drop the word, DropCnt++, Overflow=1, no WordCnt increment.
  - Write while full with a simultaneous pop: accept the word, no drop.
  - Pointers wrap modulo OUT_DEPTH; occupancy runs 0..OUT_DEPTH.
- CntClr: zero WordCnt, ErrCnt, DropCnt and Overflow. Lock, FIFO and state are unaffected. If CntClr coincides with an increment, the count ends at 0.
- RESET mid-record: the partial word is lost, the FIFO is flushed, and lock must be reacquired.

Test Plan:
- Lock: 3 commas then 0x55 then 4 commas -> Locked rises only after the 4th comma of the second run; ErrCnt=0.
- Data: locked, bytes K 0x3C, 0xA5, 0x5A, HitReady=1 -> HitValid one cycle after the 0x5A edge, HitData=0xA55A, HitSrc=1, WordCnt=1.
- Status: K 0x9C, 0x0F -> StatusValid one-cycle pulse, StatusByte=0x0F; ByteValid gaps inside the record do not break it.
- Errors: K 0x1C, K 0xBC -> ErrCnt=1, no word written. Then 3 CodeErr bytes with no comma -> Locked=0 and ErrCnt=4.
- Overflow: HitReady=0, OUT_DEPTH=8, 9 data records -> 8 words held, DropCnt=1, Overflow=1. A 10th record completing in the same cycle as a pop is accepted.
- CntClr and RESET: CntClr mid-stream -> counters 0, Locked stays 1. RESET after a header byte -> all outputs 0 and HitValid=0.
